// File: rtl/bldc_sequencer.sv
// bldc_sequencer: run-time align/ramp/run/brake/fault sequencer for the sine-PWM BLDC driver.
// Define STALL_DETECT_EN to build the feedback-based stall detector.
module bldc_sequencer #(
  parameter int ALIGN_CYCLES  = 1000000,
  parameter int ALIGN_VEL     = 20,
  parameter int RAMP_DIV      = 1000,
  parameter int STALL_CYCLES  = 5000000,
  parameter int STALL_MIN_VEL = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_start,
  input  logic               cmd_stop,
  input  logic               fault_clr,
  input  logic               fault_in,
  input  logic signed [15:0] target_vel,
  input  logic signed [7:0]  offset_cfg,
  input  logic [7:0]         torque_cfg,
  input  logic [15:0]        feedback,
  output logic               drv_enable,
  output logic signed [15:0] vel_out,
  output logic signed [7:0]  offset_out,
  output logic [7:0]         torque_out,
  output logic [2:0]         state,
  output logic               fault,
  output logic               stall
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    RAMP  = 3'd2,
    RUN   = 3'd3,
    BRAKE = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam int AV_C = ALIGN_VEL > 32767 ? 32767 : ALIGN_VEL;
  localparam logic signed [15:0] AV = 16'(AV_C);
  localparam logic [31:0] ALIGN_RLD = 32'(ALIGN_CYCLES - 1);
  localparam logic [31:0] RAMP_RLD  = 32'(RAMP_DIV - 1);

  state_t             state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic signed [15:0] vel_q, vel_d, goal, vel_step;
  logic               drv_q, drv_d, fault_q, fault_d, stall_q, stall_d;
  logic [7:0]         torque_q, torque_d;
  logic signed [7:0]  offset_q, offset_d;
  logic               step, stall_hit;

`ifdef STALL_DETECT_EN
  logic [15:0] fb_q, fb_d, abs_v;
  logic [31:0] sc_q, sc_d;
  logic        armed;
  assign abs_v     = vel_q[15] ? 16'(-vel_q) : 16'(vel_q);
  assign armed     = (state_q == RAMP || state_q == RUN) && abs_v >= 16'(STALL_MIN_VEL) && feedback == fb_q;
  assign stall_hit = armed && sc_q == 32'(STALL_CYCLES - 1);
  always_comb begin
    fb_d = feedback;
    sc_d = (state_d != state_q || !armed) ? '0 : sc_q + 32'd1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fb_q <= '0;
      sc_q <= '0;
    end else begin
      fb_q <= fb_d;
      sc_q <= sc_d;
    end
`else
  logic unused_fb;
  assign unused_fb = ^feedback;
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    step     = (state_q == RAMP || state_q == RUN || state_q == BRAKE) && cnt_q == '0;
    goal     = state_q == BRAKE ? 16'sd0 : target_vel;
    vel_step = !step ? vel_q : vel_q < goal ? vel_q + 16'sd1 : vel_q > goal ? vel_q - 16'sd1 : vel_q;
    state_d  = state_q;
    fault_d  = fault_q;
    stall_d  = stall_q;
    if (fault_in || stall_hit) begin
      state_d = FAULT;
      fault_d = 1'b1;
      stall_d = stall_q | stall_hit;
    end else begin
      case (state_q)
        IDLE:    state_d = (cmd_start && !cmd_stop && target_vel != 16'sd0) ? ALIGN : IDLE;
        ALIGN:   state_d = cmd_stop ? BRAKE : cnt_q != '0 ? ALIGN : vel_q == target_vel ? RUN : RAMP;
        RAMP:    state_d = cmd_stop ? BRAKE : vel_step == target_vel ? RUN : RAMP;
        RUN:     state_d = cmd_stop ? BRAKE : RUN;
        BRAKE:   state_d = vel_q == 16'sd0 ? IDLE : BRAKE;
        FAULT:   begin
          state_d = fault_clr ? IDLE : FAULT;
          fault_d = !fault_clr;
          stall_d = stall_q && !fault_clr;
        end
        default: state_d = IDLE;
      endcase
    end
    // prescaler reloads on entry so the first step lands RAMP_DIV cycles in
    cnt_d    = (state_d == IDLE || state_d == FAULT) ? '0 :
               state_d != state_q ? (state_d == ALIGN ? ALIGN_RLD : RAMP_RLD) :
               cnt_q == '0 ? RAMP_RLD : cnt_q - 32'd1;
    drv_d    = state_d inside {ALIGN, RAMP, RUN, BRAKE};
    vel_d    = (state_d == IDLE || state_d == FAULT) ? 16'sd0 :
               state_d == ALIGN ? (target_vel > 16'sd0 ? AV : -AV) : vel_step;
    torque_d = state_d inside {RAMP, RUN} ? torque_cfg : state_d == BRAKE ? torque_q : 8'd0;
    offset_d = offset_cfg;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      vel_q    <= '0;
      drv_q    <= 1'b0;
      fault_q  <= 1'b0;
      stall_q  <= 1'b0;
      torque_q <= '0;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vel_q    <= vel_d;
      drv_q    <= drv_d;
      fault_q  <= fault_d;
      stall_q  <= stall_d;
      torque_q <= torque_d;
      offset_q <= offset_d;
    end

  assign state      = state_q;
  assign drv_enable = drv_q;
  assign vel_out    = vel_q;
  assign torque_out = torque_q;
  assign offset_out = offset_q;
  assign fault      = fault_q;
  assign stall      = stall_q;
endmodule

// File: tb/tb_bldc_sequencer.sv
// tb_bldc_sequencer: scoreboard bench for bldc_sequencer with short align/ramp timing.
module tb_bldc_sequencer;
  localparam int AC = 10, AVEL = 20, RD = 4, SC = 50, SM = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_start = 1'b0, cmd_stop = 1'b0, fault_clr = 1'b0, fault_in = 1'b0;
  logic signed [15:0] target_vel = '0;
  logic signed [7:0]  offset_cfg = -8'sd3;
  logic [7:0]         torque_cfg = 8'd7;
  logic [15:0]        feedback = '0;
  logic               drv_enable, fault, stall;
  logic signed [15:0] vel_out;
  logic signed [7:0]  offset_out;
  logic [7:0]         torque_out;
  logic [2:0]         state;

  int checks = 0, failures = 0;
  typedef struct {string tag; int sel; int val;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bldc_sequencer #(.ALIGN_CYCLES(AC), .ALIGN_VEL(AVEL), .RAMP_DIV(RD), .STALL_CYCLES(SC), .STALL_MIN_VEL(SM)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop), .fault_clr(fault_clr),
    .fault_in(fault_in), .target_vel(target_vel), .offset_cfg(offset_cfg), .torque_cfg(torque_cfg),
    .feedback(feedback), .drv_enable(drv_enable), .vel_out(vel_out), .offset_out(offset_out),
    .torque_out(torque_out), .state(state), .fault(fault), .stall(stall)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int obs(input int sel);
    case (sel)
      0:       return int'(state);
      1:       return int'(drv_enable);
      2:       return int'(vel_out);
      3:       return int'(torque_out);
      4:       return int'(fault);
      5:       return int'(stall);
      default: return int'(offset_out);
    endcase
  endfunction

  task automatic want(input string tag, input int sel, input int val);
    sb.push_back('{tag, sel, val});
  endtask

  task automatic drain;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    drain();
  endtask

  task automatic ramp(input int from, input int to, input int mid, input int fin);
    int v = from;
    while (v != to) begin
      for (int i = 0; i < RD - 1; i++) begin
        want("ramp_hold_vel", 2, v);
        want("ramp_hold_state", 0, mid);
        tick();
      end
      v += (to > v) ? 1 : -1;
      want("ramp_step_vel", 2, v);
      want("ramp_step_state", 0, v == to ? fin : mid);
      want("ramp_drv", 1, 1);
      tick();
    end
  endtask

  task automatic start(input int tgt, input bit full);
    int av = tgt > 0 ? AVEL : -AVEL;
    target_vel = 16'(tgt);
    cmd_start = 1'b1;
    want("start_state", 0, 1);
    want("start_drv", 1, 1);
    want("start_vel", 2, av);
    want("start_torque", 3, 0);
    tick();
    cmd_start = 1'b0;
    repeat (AC - 1) begin
      want("align_state", 0, 1);
      want("align_vel", 2, av);
      tick();
    end
    want("align_exit", 0, av == tgt ? 3 : 2);
    want("ramp_torque", 3, 7);
    want("ramp_entry_vel", 2, av);
    tick();
    if (full) ramp(av, tgt, 2, 3);
  endtask

  task automatic stop_to_idle(input int v);
    cmd_stop = 1'b1;
    want("stop_state", 0, 4);
    want("stop_vel", 2, v);
    want("stop_torque", 3, 7);
    tick();
    cmd_stop = 1'b0;
    ramp(v, 0, 4, 4);
    want("idle_state", 0, 0);
    want("idle_drv", 1, 0);
    want("idle_vel", 2, 0);
    want("idle_torque", 3, 0);
    tick();
  endtask

  initial begin
    @(negedge clk);
    want("rst_state", 0, 0);
    want("rst_drv", 1, 0);
    want("rst_vel", 2, 0);
    want("rst_fault", 4, 0);
    want("rst_offset", 6, 0);
    drain();
    rst_n = 1'b1;
    want("offset_track", 6, -3);
    want("idle_hold", 0, 0);
    tick();
    target_vel = 16'sd8;
    cmd_start = 1'b1;
    cmd_stop = 1'b1;
    want("start_stop_idle", 0, 0);
    tick();
    cmd_start = 1'b0;
    cmd_stop = 1'b0;
    start(8, 1'b1);
    stop_to_idle(8);
    start(8, 1'b0);
    repeat (2) begin
      want("ramp_state", 0, 2);
      tick();
    end
    fault_in = 1'b1;
    want("fault_state", 0, 5);
    want("fault_drv", 1, 0);
    want("fault_vel", 2, 0);
    want("fault_flag", 4, 1);
    want("fault_stall", 5, 0);
    tick();
    fault_clr = 1'b1;
    want("clr_blocked_state", 0, 5);
    want("clr_blocked_fault", 4, 1);
    tick();
    fault_in = 1'b0;
    want("clr_state", 0, 0);
    want("clr_fault", 4, 0);
    want("clr_drv", 1, 0);
    tick();
    fault_clr = 1'b0;
    start(5, 1'b1);
    target_vel = -16'sd5;
    ramp(5, -5, 3, 3);
    stop_to_idle(-5);
    offset_cfg = 8'sd5;
    want("offset_new", 6, 5);
    tick();
`ifdef STALL_DETECT_EN
    start(20, 1'b1);
    repeat (SC - 1) begin
      want("stall_wait_state", 0, 3);
      tick();
    end
    want("stall_state", 0, 5);
    want("stall_flag", 5, 1);
    want("stall_fault", 4, 1);
    want("stall_drv", 1, 0);
    tick();
    fault_clr = 1'b1;
    want("stall_clr_state", 0, 0);
    want("stall_clr_flag", 5, 0);
    tick();
    fault_clr = 1'b0;
    start(20, 1'b1);
    repeat (SC + 10) begin
      feedback = ~feedback;
      want("toggle_run", 0, 3);
      tick();
    end
`else
    start(20, 1'b1);
    repeat (SC + 10) begin
      want("no_stall_state", 0, 3);
      want("no_stall_flag", 5, 0);
      tick();
    end
`endif
    stop_to_idle(20);
    target_vel = 16'sd8;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    want("async_rst_state", 0, 0);
    want("async_rst_drv", 1, 0);
    want("async_rst_vel", 2, 0);
    want("async_rst_torque", 3, 0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    target_vel = 16'sd0;
    cmd_start = 1'b1;
    want("zero_start_state", 0, 0);
    want("zero_start_drv", 1, 0);
    tick();
    cmd_start = 1'b0;
    want("zero_start_hold", 0, 0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
